// File: rtl/yolo_common_pkg.sv
// rtl/yolo_common_pkg.sv - shared delay-line state encoding and delay clamp helper
package yolo_common_pkg;

    localparam logic FILL_CODE = 1'b0;
    localparam logic RUN_CODE  = 1'b1;

    typedef enum logic {
        ST_FILL = FILL_CODE,
        ST_RUN  = RUN_CODE
    } fill_state_e;

    // Zero maps to the shortest legal delay, oversize requests saturate.
    function automatic int unsigned clamp_delay(input int unsigned cfg, input int unsigned max_delay);
        int unsigned r;
        r = cfg;
        if (cfg == 32'd0) begin
            r = 32'd1;
        end else if (cfg > max_delay) begin
            r = max_delay;
        end
        return r;
    endfunction

endpackage

// File: rtl/dly_fill_ctrl.sv
// rtl/dly_fill_ctrl.sv - active delay register, fill counter and primed flag
module dly_fill_ctrl
    import yolo_common_pkg::*;
#(
    parameter int MAX_DELAY     = 8,
    parameter int DEFAULT_DELAY = 8,
    localparam int DLY_W        = $clog2(MAX_DELAY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load_delay,
    input  logic [DLY_W-1:0] delay_cfg,
    output logic [DLY_W-1:0] active_delay,
    output logic             primed
);

    logic [DLY_W-1:0] r_active_delay;
    logic [DLY_W-1:0] r_fill_cnt;
    logic [DLY_W-1:0] w_active_delay_nxt;
    logic [DLY_W-1:0] w_fill_cnt_nxt;
    fill_state_e      w_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active_delay <= DLY_W'(DEFAULT_DELAY);
            r_fill_cnt     <= '0;
        end else begin
            r_active_delay <= w_active_delay_nxt;
            r_fill_cnt     <= w_fill_cnt_nxt;
        end
    end

    // The sample accepted in the load cycle is the first one counted for the new delay.
    always_comb begin
        w_state            = (r_fill_cnt >= r_active_delay) ? ST_RUN : ST_FILL;
        w_active_delay_nxt = r_active_delay;
        w_fill_cnt_nxt     = r_fill_cnt;
        if (load_delay) begin
            w_active_delay_nxt = DLY_W'(clamp_delay(32'(delay_cfg), MAX_DELAY));
            w_fill_cnt_nxt     = enable ? DLY_W'(1) : '0;
        end else if (enable && (w_state == ST_FILL) && (r_fill_cnt < DLY_W'(MAX_DELAY))) begin
            w_fill_cnt_nxt = r_fill_cnt + 1'b1;
        end
    end

    assign active_delay = r_active_delay;
    assign primed       = (w_state == ST_RUN);

endmodule

// File: rtl/cfg_delay_line.sv
// rtl/cfg_delay_line.sv - stall-aware runtime-configurable delay line with valid sideband
module cfg_delay_line
    import yolo_common_pkg::*;
#(
    parameter int DATA_WIDTH    = 128,
    parameter int MAX_DELAY     = 8,
    parameter int DEFAULT_DELAY = 8,
    localparam int DLY_W        = $clog2(MAX_DELAY + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  flush,
    input  logic                  load_delay,
    input  logic [DLY_W-1:0]      delay_cfg,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  primed,
    output logic [DLY_W-1:0]      active_delay
);

    logic [DATA_WIDTH-1:0] r_data [MAX_DELAY];
    logic [MAX_DELAY-1:0]  r_valid;
    logic [DLY_W-1:0]      w_active_delay;
    logic                  w_primed;
    logic                  w_tap_valid;

    dly_fill_ctrl #(
        .MAX_DELAY     (MAX_DELAY),
        .DEFAULT_DELAY (DEFAULT_DELAY)
    ) u_fill (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .load_delay   (load_delay),
        .delay_cfg    (delay_cfg),
        .active_delay (w_active_delay),
        .primed       (w_primed)
    );

    // Data stages carry no reset so they can map onto shift-register primitives.
    always_ff @(posedge clk) begin
        if (enable) begin
            r_data[0] <= data_in;
            for (int k = 1; k < MAX_DELAY; k++) begin
                r_data[k] <= r_data[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else if (enable) begin
            r_valid <= {r_valid[MAX_DELAY-2:0], valid_in};
        end
    end

    always_comb begin
        data_out    = r_data[0];
        w_tap_valid = r_valid[0];
        for (int k = 0; k < MAX_DELAY; k++) begin
            if (w_active_delay == DLY_W'(k + 1)) begin
                data_out    = r_data[k];
                w_tap_valid = r_valid[k];
            end
        end
    end

    assign valid_out    = w_tap_valid & w_primed;
    assign primed       = w_primed;
    assign active_delay = w_active_delay;

endmodule

// File: doc/cfg_delay_line.md
Name: cfg_delay_line

Overview:
- Parametrised successor to the fixed-depth per-bit shift register.
- Stall-aware, runtime-configurable delay line of DATA_WIDTH bits with a valid sideband, flush, and glitch-free delay reconfiguration.
- Used in the YOLO datapath to align side data (coordinates, tags, control) with compute pipelines whose latency depends on layer configuration.

Parameters:
- DATA_WIDTH, 128, width of data_in/data_out
- MAX_DELAY, 8, number of physical stages; legal delays 1..MAX_DELAY; must be >= 2
- DEFAULT_DELAY, 8, active delay after reset; 1..MAX_DELAY
- DLY_W, $clog2(MAX_DELAY+1), width of delay_cfg and fill count (derived, not overridden)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  advance pipeline (stall when 0)
- valid_in  in  1  qualifier for data_in
- data_in  in  DATA_WIDTH  input sample
- flush  in  1  invalidate all stages
- load_delay  in  1  single-cycle strobe: apply delay_cfg
- delay_cfg  in  DLY_W  requested delay in enable-cycles
- data_out  out  DATA_WIDTH  sample at tap active_delay
- valid_out  out  1  data_out qualifier
- primed  out  1  1 once the tap holds only post-(re)config samples
- active_delay  out  DLY_W  currently applied delay

Behaviour:
- Storage:
  - Stages s[1..MAX_DELAY] hold data; v[1..MAX_DELAY] hold valid bits.
  - Data registers are not reset, so they map to SRL/fabric shift primitives. Valid bits are reset.
- Shift: on an enable=1 cycle, s[1]<=data_in, v[1]<=valid_in, s[k]<=s[k-1], v[k]<=v[k-1]. On enable=0 every stage holds.
- Output:
  - data_out = s[active_delay]; valid_out = v[active_delay] & primed.
  - Both are combinational mux from registers, so there is no extra cycle.
  - Latency is exactly active_delay enable-cycles, independent of stall pattern.
- Reset: v all 0, active_delay=DEFAULT_DELAY, fill_cnt=0. Consequently valid_out=0 and primed=0 in the cycle after rst.
- Clamp: delay_cfg=0 -> 1; delay_cfg>MAX_DELAY -> MAX_DELAY.
- Fill counter, DLY_W bits:
  - States are FILL (fill_cnt<active_delay) and RUN (fill_cnt>=active_delay); primed = RUN.
  - In FILL, each enable cycle increments fill_cnt. The counter saturates at MAX_DELAY, and in RUN it holds.
- Reconfiguration (load_delay=1 at cycle t):
  - active_delay<=clamp(delay_cfg) at t+1.
  - fill_cnt<=enable?1:0, so the sample accepted in cycle t is the first post-switch sample. State returns to FILL.
  - The stage shift in cycle t proceeds normally; stage contents are not cleared.
  - Pre-switch samples are never presented as valid after t. The first valid output is the first valid sample accepted at or after t.
  - Reloading the same value still re-enters FILL.
- Flush: all v<=0 next cycle, including v[1]; a valid_in in the same cycle is discarded. Data, fill_cnt and active_delay are unaffected.
- Priority and simultaneous events:
  - rst > flush > shift for v.
  - flush and load_delay in the same cycle: both take effect.
  - load_delay with enable=0: fill_cnt<=0.
- Reset mid-operation: all in-flight valids are dropped. Any pending reconfiguration is lost and active_delay returns to DEFAULT_DELAY.
- Assertions for the bench:
  - valid_out implies primed.
  - active_delay stays in 1..MAX_DELAY.
  - fill_cnt never exceeds MAX_DELAY.

Decomposition:
- Shared package (yolo_common_pkg) holds the clamp function and the FILL/RUN encoding localparam.
- One natural sub-module, dly_fill_ctrl: owns active_delay, fill_cnt, clamp and the primed flag.
- The stage array and output mux remain in the top.

Test Plan:
- Default delay: rst, then enable=1 with valid_in=1 and data_in=0,1,2,...:
  - valid_out first rises at cycle 8 after the first accepted sample, with data_out=0.
  - Output then follows as 1,2,3 contiguously.
- Stall: delay 4; enable toggled 1,0,1,0,...; samples A,B,C:
  - A appears after exactly 4 enable=1 cycles, i.e. 7 clocks.
  - data_out is stable during enable=0 cycles.
- Reconfigure 8->3 mid-stream: load_delay with delay_cfg=3 at sample 20 (enable=1):
  - No pre-switch sample is valid afterwards.
  - valid_out resumes with data_out=20 exactly 3 enable-cycles later; active_delay=3.
- Clamp: delay_cfg=0 -> active_delay=1, one-cycle latency. delay_cfg=15 -> active_delay=8.
- Flush: stream at delay 5, assert flush with valid_in=1 and data_in=99:
  - valid_out=0 for the next 5 enable-cycles; 99 never appears.
  - primed stays 1 throughout.
- Reset mid-stream: rst at delay 3 with a full pipeline:
  - valid_out=0 and active_delay=8 next cycle.
  - No stale sample emerges after rst deasserts.
